// File: rtl/mem_map_pkg.sv
// Shared memory map, micro-op codes and load/store sequencer state type.
package mem_map_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned UOP_W  = 5;
  localparam int unsigned RD_W   = 4;
  localparam int unsigned DCA_W  = 5;
  localparam int unsigned CNT_W  = 8;

  localparam logic [UOP_W-1:0]  UOP_LDR      = 5'd10;
  localparam logic [UOP_W-1:0]  UOP_STR      = 5'd11;
  localparam logic [ADDR_W-1:0] DCACHE_LIMIT = 32'd31;
  localparam logic [ADDR_W-1:0] GPIO_ADDR    = 32'd31;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } ls_state_t;

endpackage

// File: rtl/load_store_ctrl.sv
// Execute-stage LDR/STR sequencer: address decode, D-cache handshake, GPIO
// strobe, pipeline stall and the registered write-back beat.
module load_store_ctrl
  import mem_map_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [UOP_W-1:0]  op_uop,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [DATA_W-1:0] op_wdata,
  input  logic [RD_W-1:0]   op_rd,
  input  logic [DATA_W-1:0] alu_result,
  output logic              stall,
  output logic              dc_req,
  output logic              dc_we,
  output logic [DCA_W-1:0]  dc_addr,
  output logic [DATA_W-1:0] dc_wdata,
  input  logic [DATA_W-1:0] dc_rdata,
  input  logic              dc_ack,
  output logic              gpio_we,
  output logic [DATA_W-1:0] gpio_wdata,
  input  logic [DATA_W-1:0] gpio_state,
  output logic              wb_valid,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              fault
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ls_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dc_req_q, dc_req_d;
  logic              dc_we_q, dc_we_d;
  logic [DCA_W-1:0]  dc_addr_q, dc_addr_d;
  logic [DATA_W-1:0] dc_wdata_q, dc_wdata_d;
  logic              gpio_we_q, gpio_we_d;
  logic [DATA_W-1:0] gpio_wdata_q, gpio_wdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              fault_q, fault_d;
  logic              stall_c;

  logic is_ld, is_st, is_mem, in_dc, in_gpio, timeout_c;

  assign is_ld     = (op_uop == UOP_LDR);
  assign is_st     = (op_uop == UOP_STR);
  assign is_mem    = is_ld | is_st;
  assign in_dc     = (op_addr < DCACHE_LIMIT);
  assign in_gpio   = (op_addr == GPIO_ADDR);
  assign timeout_c = (cnt_q == CNT_LAST) && !dc_ack;

  // Next-state, latched request fields and write-back beat.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dc_req_d     = dc_req_q;
    dc_we_d      = dc_we_q;
    dc_addr_d    = dc_addr_q;
    dc_wdata_d   = dc_wdata_q;
    gpio_we_d    = 1'b0;
    gpio_wdata_d = gpio_wdata_q;
    wb_valid_d   = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    fault_d      = 1'b0;
    stall_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (op_valid) begin
          wb_rd_d = op_rd;
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_data_d  = alu_result;
          end else if (in_dc) begin
            stall_c    = 1'b1;
            state_d    = WAIT;
            cnt_d      = '0;
            dc_req_d   = 1'b1;
            dc_we_d    = is_st;
            dc_addr_d  = op_addr[DCA_W-1:0];
            dc_wdata_d = op_wdata;
          end else if (in_gpio) begin
            if (is_ld) begin
              wb_valid_d = 1'b1;
              wb_data_d  = gpio_state;
            end else begin
              gpio_we_d    = 1'b1;
              gpio_wdata_d = op_wdata;
            end
          end else begin
            fault_d = 1'b1;
            if (is_ld) begin
              wb_valid_d = 1'b1;
              wb_data_d  = '0;
            end
          end
        end
      end
      WAIT: begin
        cnt_d = CNT_W'(cnt_q + 8'd1);
        if (dc_ack) begin
          state_d  = IDLE;
          dc_req_d = 1'b0;
          if (!dc_we_q) begin
            wb_valid_d = 1'b1;
            wb_data_d  = dc_rdata;
          end
        end else if (timeout_c) begin
          state_d  = IDLE;
          dc_req_d = 1'b0;
          fault_d  = 1'b1;
          if (!dc_we_q) begin
            wb_valid_d = 1'b1;
            wb_data_d  = '0;
          end
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dc_req_q     <= 1'b0;
      dc_we_q      <= 1'b0;
      dc_addr_q    <= '0;
      dc_wdata_q   <= '0;
      gpio_we_q    <= 1'b0;
      gpio_wdata_q <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dc_req_q     <= dc_req_d;
      dc_we_q      <= dc_we_d;
      dc_addr_q    <= dc_addr_d;
      dc_wdata_q   <= dc_wdata_d;
      gpio_we_q    <= gpio_we_d;
      gpio_wdata_q <= gpio_wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      fault_q      <= fault_d;
    end
  end

  // Stall is combinational so upstream advances in the ack/abort cycle; reset forces it low.
  assign stall      = stall_c && !rst;
  assign dc_req     = dc_req_q;
  assign dc_we      = dc_we_q;
  assign dc_addr    = dc_addr_q;
  assign dc_wdata   = dc_wdata_q;
  assign gpio_we    = gpio_we_q;
  assign gpio_wdata = gpio_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_load_store_ctrl.sv
// Directed plus randomized checks of load_store_ctrl against a per-op outcome model.
module tb_load_store_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [4:0]  op_uop;
  logic [31:0] op_addr, op_wdata, alu_result;
  logic [3:0]  op_rd;
  logic        stall, dc_req, dc_we, dc_ack, gpio_we, wb_valid, fault;
  logic [4:0]  dc_addr;
  logic [31:0] dc_wdata, dc_rdata, gpio_wdata, gpio_state, wb_data;
  logic [3:0]  wb_rd;

  int n_cmp = 0;
  int n_err = 0;

  load_store_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_uop(op_uop), .op_addr(op_addr),
    .op_wdata(op_wdata), .op_rd(op_rd), .alu_result(alu_result),
    .stall(stall), .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr),
    .dc_wdata(dc_wdata), .dc_rdata(dc_rdata), .dc_ack(dc_ack),
    .gpio_we(gpio_we), .gpio_wdata(gpio_wdata), .gpio_state(gpio_state),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one op (entered and left at a negedge). ack_n: WAIT cycle of dc_ack, <0 = never.
  task automatic run_op(input logic [4:0] uop, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] alu, input logic [31:0] gst, input logic [31:0] rdata,
                        input logic [3:0] rd, input int ack_n);
    bit is_ld, is_st, mem, dc, gp, um, tmo;
    int exp_stall, stalls, reqs, k;
    logic [31:0] exp_data;
    is_ld = (uop == 5'd10);
    is_st = (uop == 5'd11);
    mem   = is_ld || is_st;
    dc    = mem && (addr < 32'd31);
    gp    = mem && (addr == 32'd31);
    um    = mem && (addr > 32'd31);
    tmo   = dc && (ack_n < 0 || ack_n >= TO);
    exp_stall = !dc ? 0 : (tmo ? TO : 1 + ack_n);
    exp_data  = !mem ? alu : um ? 32'd0 : gp ? gst : tmo ? 32'd0 : rdata;

    op_valid = 1'b1; op_uop = uop; op_addr = addr; op_wdata = wdata;
    alu_result = alu; op_rd = rd; gpio_state = gst; dc_rdata = rdata; dc_ack = 1'b0;
    stalls = 0; reqs = 0; k = 0;
    forever begin
      if (k > 0) dc_ack = ((k - 1) == ack_n);
      if (k == 1) begin
        chk("dc_addr", 32'(dc_addr), 32'(addr[4:0]));
        chk("dc_we", 32'(dc_we), 32'(is_st));
        chk("dc_wdata", dc_wdata, wdata);
      end
      #1;
      if (stall) stalls++;
      if (dc_req) reqs++;
      if (!stall) break;
      step();
      k++;
      if (k > 300) begin
        chk("stall_bound", 32'(k), 32'd0);
        break;
      end
    end
    step();
    op_valid = 1'b0; dc_ack = 1'b0;
    gpio_state = $urandom; dc_rdata = $urandom;
    chk("stall_cycles", 32'(stalls), 32'(exp_stall));
    chk("dc_req_cycles", 32'(reqs), dc ? 32'(exp_stall) : 32'd0);
    chk("wb_valid", 32'(wb_valid), 32'(!mem || is_ld));
    if (!mem || is_ld) begin
      chk("wb_data", wb_data, exp_data);
      chk("wb_rd", 32'(wb_rd), 32'(rd));
    end
    chk("gpio_we", 32'(gpio_we), 32'(gp && is_st));
    if (gp && is_st) chk("gpio_wdata", gpio_wdata, wdata);
    chk("fault", 32'(fault), 32'(um || tmo));
    chk("dc_req_done", 32'(dc_req), 32'd0);
    // Idle cycle with a stray ack: pulses must not repeat and the ack is ignored.
    dc_ack = 1'b1;
    step();
    dc_ack = 1'b0;
    chk("idle_quiet", {29'd0, wb_valid, gpio_we, fault}, 32'd0);
    chk("idle_no_req", 32'(dc_req), 32'd0);
  endtask

  initial begin
    logic [4:0]  ru;
    logic [31:0] ra;
    int sel, reg_sel, an;

    rst = 1'b1; op_valid = 1'b0; op_uop = '0; op_addr = '0; op_wdata = '0;
    op_rd = '0; alu_result = '0; dc_rdata = '0; dc_ack = 1'b0; gpio_state = '0;
    step();
    step();
    chk("rst_outs", {25'd0, stall, dc_req, dc_we, gpio_we, wb_valid, fault, 1'b0}, 32'd0);
    chk("rst_data", wb_data | gpio_wdata | dc_wdata | 32'(dc_addr) | 32'(wb_rd), 32'd0);
    rst = 1'b0;
    step();

    // Back-to-back ALU ops.
    op_valid = 1'b1; op_uop = 5'd0; alu_result = 32'hA5; op_rd = 4'd3;
    #1 chk("alu1_stall", 32'(stall), 32'd0);
    step();
    chk("alu1_valid", 32'(wb_valid), 32'd1);
    chk("alu1_data", wb_data, 32'hA5);
    alu_result = 32'h5A; op_rd = 4'd4;
    #1 chk("alu2_stall", 32'(stall), 32'd0);
    step();
    op_valid = 1'b0;
    chk("alu2_valid", 32'(wb_valid), 32'd1);
    chk("alu2_data", wb_data, 32'h5A);
    chk("alu2_rd", 32'(wb_rd), 32'd4);
    step();
    chk("alu_end", 32'(wb_valid), 32'd0);

    // Directed scenarios.
    run_op(5'd10, 32'd5, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 4'd7, 3);
    run_op(5'd11, 32'd31, 32'h0F, 32'h0, 32'h0, 32'h0, 4'd1, -1);
    run_op(5'd10, 32'd31, 32'h0, 32'h0, 32'h0F, 32'h0, 4'd2, -1);
    run_op(5'd10, 32'd32, 32'h0, 32'h0, 32'h0, 32'h0, 4'd5, -1);
    run_op(5'd11, 32'hFFFFFFFF, 32'h1234, 32'h0, 32'h0, 32'h0, 4'd6, -1);
    run_op(5'd10, 32'd2, 32'h0, 32'h0, 32'h0, 32'h11111111, 4'd8, -1);
    run_op(5'd10, 32'd2, 32'h0, 32'h0, 32'h0, 32'h22222222, 4'd9, TO - 1);
    run_op(5'd11, 32'd30, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 4'd10, 0);
    run_op(5'd11, 32'd0, 32'h0BADF00D, 32'h0, 32'h0, 32'h0, 4'd11, -1);

    // Reset in WAIT cycle 2.
    op_valid = 1'b1; op_uop = 5'd10; op_addr = 32'd5; op_rd = 4'd12; dc_ack = 1'b0;
    step();
    step();
    step();
    chk("pre_rst_req", 32'(dc_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_outs", {26'd0, stall, dc_req, gpio_we, wb_valid, fault, 1'b0}, 32'd0);
    chk("mid_rst_addr", 32'(dc_addr), 32'd0);
    op_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_quiet", {30'd0, wb_valid, dc_req}, 32'd0);
    run_op(5'd3, 32'd5, 32'h0, 32'h600DCAFE, 32'h0, 32'h0, 4'd13, -1);

    // Randomized ops.
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 2));
      ru = 5'($urandom_range(0, 31));
      if (ru == 5'd10 || ru == 5'd11) ru = 5'd0;
      if (sel == 1) ru = 5'd10;
      if (sel == 2) ru = 5'd11;
      reg_sel = int'($urandom_range(0, 3));
      if (reg_sel < 2) ra = 32'($urandom_range(0, 30));
      else if (reg_sel == 2) ra = 32'd31;
      else ra = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'(32 + $urandom_range(0, 1000));
      an = int'($urandom_range(0, 6)) - 1;
      run_op(ru, ra, $urandom, $urandom, $urandom, $urandom, 4'($urandom_range(0, 15)), an);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
